// File: rtl/segre_cache_controller.sv
// Blocking single-request cache controller: tag lookup, line refill from main memory and victim selection.
// Replacement is round-robin by default; define SEGRE_CACHE_LRU_EN for age-based LRU.
package EPI_pkg;
    localparam int WORD_SIZE = 32;
endpackage

module segre_cache_controller
    import EPI_pkg::*;
#(
    parameter  int NUM_LANES       = 4,
    parameter  int BYTES_PER_LANE  = 16,
    localparam int ADDR_BYTE_SIZE  = $clog2(BYTES_PER_LANE),
    localparam int ADDR_INDEX_SIZE = $clog2(NUM_LANES)
) (
    input  logic                       clk_i,
    input  logic                       rsn_i,
    input  logic                       req_i,
    input  logic [WORD_SIZE-1:0]       addr_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic                       tag_req_o,
    output logic [WORD_SIZE-1:0]       tag_addr_o,
    input  logic                       hit_i,
    input  logic                       miss_i,
    output logic                       fill_o,
    output logic [ADDR_INDEX_SIZE-1:0] victim_index_o,
    output logic                       mm_req_o,
    output logic [WORD_SIZE-1:0]       mm_addr_o,
    input  logic                       mm_gnt_i,
    input  logic                       mm_rvalid_i,
    output logic [15:0]                hit_cnt_o,
    output logic [15:0]                miss_cnt_o
);

    typedef enum logic [2:0] {IDLE, LOOKUP, MM_REQ, MM_WAIT, FILL} state_t;

    state_t               state_q, state_d;
    logic [WORD_SIZE-1:0] addr_q;
    logic                 accept, hit_evt, miss_evt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Strobes decode from the state register alone, so reset clears them without a clock.
    // NOTE: every output of this block gets a default first; a missed branch would infer a latch.
    always_comb begin
        state_d   = state_q;
        ready_o   = 1'b0;
        tag_req_o = 1'b0;
        mm_req_o  = 1'b0;
        fill_o    = 1'b0;
        accept    = 1'b0;
        hit_evt   = 1'b0;
        miss_evt  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (req_i) begin
                    accept  = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                tag_req_o = 1'b1;
                if (miss_i) begin
                    miss_evt = 1'b1;
                    state_d  = MM_REQ;
                end else if (hit_i) begin
                    hit_evt = 1'b1;
                    state_d = IDLE;
                end
            end
            MM_REQ: begin
                mm_req_o = 1'b1;
                if (mm_gnt_i) state_d = mm_rvalid_i ? FILL : MM_WAIT;
            end
            MM_WAIT: begin
                if (mm_rvalid_i) state_d = FILL;
            end
            FILL: begin
                fill_o  = 1'b1;
                state_d = LOOKUP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            addr_q     <= '0;
            valid_o    <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            valid_o <= hit_evt;
            if (accept) addr_q <= addr_i;
            if (hit_evt && hit_cnt_o != 16'hFFFF)   hit_cnt_o  <= hit_cnt_o + 16'd1;
            if (miss_evt && miss_cnt_o != 16'hFFFF) miss_cnt_o <= miss_cnt_o + 16'd1;
        end
    end

    assign tag_addr_o = addr_q;
    assign mm_addr_o  = addr_q & ~WORD_SIZE'(BYTES_PER_LANE - 1);

`ifdef SEGRE_CACHE_LRU_EN
    // age 0 is most recently used; the lane holding the oldest age is the victim.
    logic [ADDR_INDEX_SIZE-1:0] age_q [NUM_LANES];
    logic [ADDR_INDEX_SIZE-1:0] touch_lane;

    assign touch_lane = fill_o ? victim_index_o : addr_q[ADDR_BYTE_SIZE +: ADDR_INDEX_SIZE];

    // NOTE: this small array is reset because the victim choice depends on its starting order.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int i = 0; i < NUM_LANES; i++) age_q[i] <= ADDR_INDEX_SIZE'(i);
        end else if (hit_evt || fill_o) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (ADDR_INDEX_SIZE'(i) == touch_lane)  age_q[i] <= '0;
                else if (age_q[i] < age_q[touch_lane]) age_q[i] <= age_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        victim_index_o = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (age_q[i] == ADDR_INDEX_SIZE'(NUM_LANES - 1)) victim_index_o = ADDR_INDEX_SIZE'(i);
        end
    end
`else
    logic [ADDR_INDEX_SIZE-1:0] rr_q;

    // Power-of-two lane count lets the pointer wrap by natural overflow.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i)      rr_q <= '0;
        else if (fill_o) rr_q <= rr_q + 1'b1;
    end

    assign victim_index_o = rr_q;
`endif

endmodule

// File: tb/tb_segre_cache_controller.sv
// Directed bench for segre_cache_controller: a transaction-level model predicts every output each cycle.
// Replacement expectations follow SEGRE_CACHE_LRU_EN the same way the design does.
module tb_segre_cache_controller;

    localparam int NL  = 4;
    localparam int BPL = 16;

    logic        clk_i, rsn_i, req_i, hit_i, miss_i, mm_gnt_i, mm_rvalid_i;
    logic [31:0] addr_i, tag_addr_o, mm_addr_o;
    logic        ready_o, valid_o, tag_req_o, fill_o, mm_req_o;
    logic [1:0]  victim_index_o;
    logic [15:0] hit_cnt_o, miss_cnt_o;

    segre_cache_controller #(.NUM_LANES(NL), .BYTES_PER_LANE(BPL)) dut (
        .clk_i(clk_i), .rsn_i(rsn_i), .req_i(req_i), .addr_i(addr_i),
        .ready_o(ready_o), .valid_o(valid_o), .tag_req_o(tag_req_o), .tag_addr_o(tag_addr_o),
        .hit_i(hit_i), .miss_i(miss_i), .fill_o(fill_o), .victim_index_o(victim_index_o),
        .mm_req_o(mm_req_o), .mm_addr_o(mm_addr_o), .mm_gnt_i(mm_gnt_i), .mm_rvalid_i(mm_rvalid_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    // Model state: expected strobes, counters, latched address, recency list (front = most recent).
    bit          chk_en = 1'b0;
    bit          e_ready, e_tag, e_mm, e_fill, e_valid;
    int          m_hits, m_misses, rr_ptr;
    logic [31:0] m_addr;
    int          lru_q[$];
    logic [31:0] last_victim;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int lane_of(input logic [31:0] a);
        return int'((a / BPL) % NL);
    endfunction

    function automatic int model_victim();
`ifdef SEGRE_CACHE_LRU_EN
        return lru_q[lru_q.size() - 1];
`else
        return rr_ptr;
`endif
    endfunction

    task automatic model_touch(input int lane);
        int pos = 0;
        for (int j = 0; j < lru_q.size(); j++) if (lru_q[j] == lane) pos = j;
        lru_q.delete(pos);
        lru_q.push_front(lane);
    endtask

    task automatic model_fill();
        model_touch(model_victim());
        rr_ptr = (rr_ptr + 1) % NL;
    endtask

    task automatic model_reset();
        m_hits = 0; m_misses = 0; m_addr = '0; rr_ptr = 0;
        lru_q.delete();
        for (int i = 0; i < NL; i++) lru_q.push_back(i);
    endtask

    task automatic set_exp(input bit r, input bit t, input bit m, input bit f, input bit v);
        e_ready = r; e_tag = t; e_mm = m; e_fill = f; e_valid = v;
    endtask

    // Single compare process: all outputs against the model, mid-cycle.
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("ready_o",        ready_o,        e_ready);
            check("tag_req_o",      tag_req_o,      e_tag);
            check("mm_req_o",       mm_req_o,       e_mm);
            check("fill_o",         fill_o,         e_fill);
            check("valid_o",        valid_o,        e_valid);
            check("hit_cnt_o",      hit_cnt_o,      m_hits);
            check("miss_cnt_o",     miss_cnt_o,     m_misses);
            check("tag_addr_o",     tag_addr_o,     m_addr);
            check("mm_addr_o",      mm_addr_o,      m_addr & ~32'(BPL - 1));
            check("victim_index_o", victim_index_o, model_victim());
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        req_i = 0; addr_i = '0; hit_i = 0; miss_i = 0; mm_gnt_i = 0; mm_rvalid_i = 0;
    endtask

    // Asserts reset between edges and checks strobes drop before any clock arrives.
    task automatic apply_reset();
        chk_en = 1'b0;
        rsn_i  = 1'b0;
        #1;
        check("rst_async_mm_req",  mm_req_o,  0);
        check("rst_async_fill",    fill_o,    0);
        check("rst_async_valid",   valid_o,   0);
        check("rst_async_tag_req", tag_req_o, 0);
        clear_inputs();
        model_reset();
        set_exp(1, 0, 0, 0, 0);
        repeat (2) tick();
        #2 rsn_i = 1'b1;
        tick();
        chk_en = 1'b1;
    endtask

    task automatic accept_req(input logic [31:0] a);
        req_i = 1; addr_i = a;
        tick();
        req_i = 0; addr_i = ~a;
        m_addr = a;
        set_exp(0, 1, 0, 0, 0);
    endtask

    task automatic lookup_hit(input logic [31:0] a);
        hit_i = 1;
        tick();
        hit_i = 0;
        if (m_hits < 65535) m_hits++;
        model_touch(lane_of(a));
        set_exp(1, 0, 0, 0, 1);
        tick();
        set_exp(1, 0, 0, 0, 0);
    endtask

    task automatic lookup_miss(input bit both);
        miss_i = 1; hit_i = both;
        tick();
        miss_i = 0; hit_i = 0;
        if (m_misses < 65535) m_misses++;
        set_exp(0, 0, 1, 0, 0);
    endtask

    // One complete request from IDLE back to IDLE.
    task automatic access(input logic [31:0] a, input int stall, input bit miss, input bit both,
                          input int gnt_wait, input bit rv_with_gnt, input int rv_wait);
        accept_req(a);
        repeat (stall) tick();
        if (!miss) begin
            lookup_hit(a);
        end else begin
            lookup_miss(both);
            repeat (gnt_wait) tick();
            mm_gnt_i = 1; mm_rvalid_i = rv_with_gnt;
            tick();
            mm_gnt_i = 0; mm_rvalid_i = 0;
            if (!rv_with_gnt) begin
                set_exp(0, 0, 0, 0, 0);
                repeat (rv_wait) tick();
                mm_rvalid_i = 1;
                tick();
                mm_rvalid_i = 0;
            end
            set_exp(0, 0, 0, 1, 0);
            last_victim = 32'(victim_index_o);
            tick();
            model_fill();
            set_exp(0, 1, 0, 0, 0);
            lookup_hit(a);
        end
    endtask

    initial begin
        automatic int exp_seq[5] = '{0, 1, 2, 3, 0};
        rsn_i = 1'b1;
        clear_inputs();
        #2;
        apply_reset();
        check("reset_ready",    ready_o,    1);
        check("reset_hit_cnt",  hit_cnt_o,  0);
        check("reset_miss_cnt", miss_cnt_o, 0);
        check("reset_tag_addr", tag_addr_o, 0);
`ifdef SEGRE_CACHE_LRU_EN
        check("reset_victim", victim_index_o, 3);
`else
        check("reset_victim", victim_index_o, 0);
`endif
        repeat (2) tick();

        // Plain hit: valid two cycles after acceptance, no memory traffic.
        access(32'h100, 0, 0, 0, 0, 0, 0);
        check("hit_only_hits",   hit_cnt_o,  1);
        check("hit_only_misses", miss_cnt_o, 0);

        // Miss with grant after 3 cycles and data 5 cycles after grant.
        apply_reset();
        access(32'h1234, 0, 1, 0, 3, 0, 4);
        check("miss_mm_addr",  mm_addr_o,  32'h1230);
        check("miss_tag_addr", tag_addr_o, 32'h1234);
        check("miss_misses",   miss_cnt_o, 1);
        check("miss_hits",     hit_cnt_o,  1);

        // Grant and data together: MM_WAIT skipped.
        access(32'h2250, 0, 1, 0, 0, 1, 0);
        check("fast_fill_hits", hit_cnt_o, 2);

        // Lookup stalls with neither result, then both results high counts as a miss.
        access(32'h3370, 2, 1, 1, 1, 0, 2);
        check("both_high_misses", miss_cnt_o, 3);
        access(32'h0440, 3, 0, 0, 0, 0, 0);
        check("stall_hit_hits", hit_cnt_o, 4);

`ifdef SEGRE_CACHE_LRU_EN
        // Fill lanes 3,2,1,0 in turn, then touch lane 3 with a hit.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            access(32'h5030 - 32'(i * 16), 0, 1, 0, 0, 0, 1);
            check("lru_fill_lane", last_victim, 32'(3 - i));
        end
        access(32'h6030, 0, 0, 0, 0, 0, 0);
        check("lru_victim_after_hit", victim_index_o, 2);
`else
        // Five back-to-back misses walk the pointer 0,1,2,3,0; a hit does not move it.
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            access(32'h4000 + 32'(i * 16), 0, 1, 0, i % 2, 0, 1);
            check("rr_victim_seq", last_victim, 32'(exp_seq[i]));
        end
        access(32'h0010, 0, 0, 0, 0, 0, 0);
        access(32'h7020, 0, 1, 0, 0, 1, 0);
        check("rr_after_hit", last_victim, 1);
`endif

        // Reset while requesting main memory: request dropped, state cleared.
        accept_req(32'h8888);
        lookup_miss(1'b0);
        tick();
        apply_reset();
        check("rst_mmreq_hits",     hit_cnt_o,  0);
        check("rst_mmreq_misses",   miss_cnt_o, 0);
        check("rst_mmreq_tag_addr", tag_addr_o, 0);

        // Reset while waiting for data; the late data must not cause a fill.
        accept_req(32'h9990);
        lookup_miss(1'b0);
        mm_gnt_i = 1;
        tick();
        mm_gnt_i = 0;
        set_exp(0, 0, 0, 0, 0);
        tick();
        apply_reset();
        mm_rvalid_i = 1;
        tick();
        tick();
        mm_rvalid_i = 0;
        check("late_rvalid_fill",  fill_o,   0);
        check("late_rvalid_ready", ready_o,  1);
        check("late_rvalid_mmreq", mm_req_o, 0);
        access(32'h100, 0, 0, 0, 0, 0, 0);
        check("post_reset_hits", hit_cnt_o, 1);

        repeat (2) tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
